csr_counter_unit: RTL and testbench
===================================

CSR_COUNTER_UNIT -- requirements
Module: csr_counter_unit

Interface
REQ-001 SHALL have parameter NUM_HPM, default 4, meaning number of event counters hpmcounter3..(3+NUM_HPM-1), legal range 0..29.
REQ-002 SHALL have parameter CNT_WIDTH, default 64, meaning implemented counter width, legal range 33..64.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port csr_ren  input  1  read request.
REQ-006 SHALL have port csr_raddr  input  12  read address.
REQ-007 SHALL have port csr_rdata  output  32  read data, registered, valid one cycle after csr_ren.
REQ-008 SHALL have port csr_rvalid  output  1  pulses with csr_rdata.
REQ-009 SHALL have port csr_wen  input  1  write request.
REQ-010 SHALL have port csr_waddr  input  12  write address.
REQ-011 SHALL have port csr_wdata  input  32  write operand.
REQ-012 SHALL have port csr_op  input  2  00 write, 01 set bits, 10 clear bits, 11 reserved (treated as write).
REQ-013 SHALL have port inst_done  input  1  one instruction retired this cycle.
REQ-014 SHALL have port hpm_event  input  max(NUM_HPM,1)  per-counter event strobe, bit i drives hpmcounter(3+i).
REQ-015 SHALL have port csr_illegal  output  1  registered pulse flagging an illegal access.

Function
REQ-016 SHALL implement counters cycle, instret, and NUM_HPM event counters, each CNT_WIDTH bits.
REQ-017 SHALL map read-only user views: 0xC00 cycle, 0xC01 time (alias of cycle), 0xC02 instret, 0xC03+i hpm i; high halves at 0xC80, 0xC81, 0xC82, 0xC83+i.
REQ-018 SHALL map writable machine views: 0xB00 mcycle, 0xB02 minstret, 0xB03+i mhpm i; high halves 0xB80, 0xB82, 0xB83+i; 0x320 mcountinhibit.
REQ-019 SHALL implement mcountinhibit bit0 (CY), bit2 (IR), bits 3..3+NUM_HPM-1 (HPM); all other bits read 0, writes ignored.
REQ-020 SHALL increment cycle every cycle unless CY set; instret on inst_done unless IR set; hpm i on hpm_event[i] unless its inhibit bit set.
REQ-021 SHALL wrap each counter from 2^CNT_WIDTH-1 to 0 without flag.
REQ-022 SHALL read counter bits above CNT_WIDTH as 0 in high-half views; writes to those bits discarded.
REQ-023 SHALL register reads: csr_rdata/csr_rvalid update the cycle after csr_ren=1, returning value held before that edge; csr_rdata=0 when csr_rvalid=0.
REQ-024 SHALL compute write value as wdata (op 00/11), old|wdata (01), old&~wdata (10), old being current 32-bit half.
REQ-025 SHALL give a write priority over same-cycle increment of the written counter; other half unaffected and not incremented that cycle.
REQ-026 SHALL propagate carry normally when a write to one half coincides with increment touching neither written half (i.e. other counters).
REQ-027 SHALL, on same-cycle read and write of the same counter, return the pre-write value.
REQ-028 SHALL flag illegal, one-cycle pulse after the request: read of unmapped address, write to unmapped address, write to any 0xCxx address; hpm addresses with index>=NUM_HPM are unmapped.
REQ-029 SHALL leave state unchanged on illegal write and return csr_rdata=0 with csr_rvalid=1 on illegal read.
REQ-030 SHALL apply new mcountinhibit from the cycle after its write; the write cycle still uses the old value.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, clear all counters, mcountinhibit, csr_rdata, csr_rvalid, csr_illegal to 0, overriding any concurrent read, write or event.
REQ-032 SHALL resume counting on the first edge with rst=0 (cycle reads 1 one edge after release).

Verification
REQ-033 SHALL verify: release reset, read 0xC00 three edges later -> csr_rdata=3 one cycle after request, csr_rvalid=1.
REQ-034 SHALL verify: write 0xB00=0xFFFFFFFF, 0xB80=0 with CY clear -> two edges later read 0xC80 returns 1 (carry into high half).
REQ-035 SHALL verify: CNT_WIDTH=40, write 0xB82=0xFFFFFFFF -> read 0xC82 returns 0x000000FF; minstret at all-ones plus inst_done wraps to 0.
REQ-036 SHALL verify: csr_op=01 wdata=0x5 to 0x320 -> cycle and instret freeze, hpm0 keeps counting; op=10 wdata=0x1 resumes cycle.
REQ-037 SHALL verify: write 0xC00 and read 0xB03+NUM_HPM -> csr_illegal=1 each, counters unchanged, csr_rdata=0.
REQ-038 SHALL verify: write 0xB03=0x10 coincident with hpm_event[0]=1 -> next read returns 0x10; rst asserted mid-stream zeroes all views.

Source files
------------

// File: rtl/csr_counter_unit_if.sv
// CSR access bus for the counter unit: read/write requests in, registered response out.
interface csr_counter_unit_if;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [1:0]  csr_op;
    logic        csr_illegal;

    modport master (
        output csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata, csr_op,
        input  csr_rdata, csr_rvalid, csr_illegal
    );

    modport slave (
        input  csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata, csr_op,
        output csr_rdata, csr_rvalid, csr_illegal
    );
endinterface

// File: rtl/csr_counter_unit.sv
// Cycle/instret/HPM counter block with user read-only views, machine
// writable views and mcountinhibit, accessed through a registered CSR port.
module csr_counter_unit #(
    parameter int unsigned NUM_HPM   = 4,
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                                    clk,
    input  logic                                    rst,
    csr_counter_unit_if.slave                       csr,
    input  logic                                    inst_done,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event
);

    // Counter slots: 0 = cycle, 1 = instret, 2+i = hpm i
    localparam int unsigned NUM_CNT  = NUM_HPM + 2;
    localparam logic [31:0] INH_MASK =
        32'(((64'd1 << NUM_HPM) - 64'd1) << 3) | 32'h0000_0005;

    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
    logic [31:0]          inh_q, inh_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 illegal_q, illegal_d;

    logic [7:0]  rdec, wdec;
    logic [63:0] rsel, wsel, wnew;
    logic [31:0] wold, wval;

    assign csr.csr_rdata   = rdata_q;
    assign csr.csr_rvalid  = rvalid_q;
    assign csr.csr_illegal = illegal_q;

    // Address decode: {ok, is_inhibit, high_half, slot[4:0]}; 0xCxx is never writable
    function automatic logic [7:0] decode(input logic [11:0] addr, input logic is_wr);
        logic       ok;
        logic [4:0] idx;
        logic [4:0] off;
        ok  = 1'b0;
        idx = 5'd0;
        off = addr[4:0];
        if (addr == 12'h320) begin
            ok = 1'b1;
        end else if ((addr[11:8] == 4'hB || (addr[11:8] == 4'hC && !is_wr)) &&
                     addr[6:5] == 2'b00) begin
            if (off == 5'd0) begin
                ok = 1'b1;
            end else if (off == 5'd1) begin
                ok = (addr[11:8] == 4'hC);
            end else if (off == 5'd2) begin
                ok  = 1'b1;
                idx = 5'd1;
            end else if (32'(off) < 32'(NUM_HPM) + 32'd3) begin
                ok  = 1'b1;
                idx = off - 5'd1;
            end
        end
        return {ok, (addr == 12'h320), addr[7], idx};
    endfunction

    // Next-state: increments, CSR write (wins over increment of its counter), read response
    always_comb begin
        for (int unsigned k = 0; k < NUM_CNT; k++) begin
            cnt_d[k] = cnt_q[k];
        end
        inh_d     = inh_q;
        rdata_d   = 32'd0;
        rvalid_d  = csr.csr_ren;
        illegal_d = 1'b0;
        rsel      = 64'd0;
        wsel      = 64'd0;
        wnew      = 64'd0;
        wval      = 32'd0;

        rdec = decode(csr.csr_raddr, 1'b0);
        wdec = decode(csr.csr_waddr, 1'b1);

        // Counter selection for both ports, zero-extended to 64 bits
        for (int unsigned k = 0; k < NUM_CNT; k++) begin
            if (rdec[4:0] == 5'(k)) rsel = 64'(cnt_q[k]);
            if (wdec[4:0] == 5'(k)) wsel = 64'(cnt_q[k]);
        end

        if (csr.csr_ren) begin
            if (!rdec[7]) begin
                illegal_d = 1'b1;
            end else if (rdec[6]) begin
                rdata_d = inh_q;
            end else begin
                rdata_d = rdec[5] ? rsel[63:32] : rsel[31:0];
            end
        end

        // Increments use the inhibit value held before this edge
        if (!inh_q[0]) cnt_d[0] = cnt_q[0] + CNT_WIDTH'(1);
        if (inst_done && !inh_q[2]) cnt_d[1] = cnt_q[1] + CNT_WIDTH'(1);
        for (int unsigned i = 0; i < NUM_HPM; i++) begin
            if (hpm_event[i] && !inh_q[3+i]) cnt_d[2+i] = cnt_q[2+i] + CNT_WIDTH'(1);
        end

        wold = wdec[6] ? inh_q : (wdec[5] ? wsel[63:32] : wsel[31:0]);
        case (csr.csr_op)
            2'b01:   wval = wold | csr.csr_wdata;
            2'b10:   wval = wold & ~csr.csr_wdata;
            default: wval = csr.csr_wdata;
        endcase
        wnew = wdec[5] ? {wval, wsel[31:0]} : {wsel[63:32], wval};

        if (csr.csr_wen) begin
            if (!wdec[7]) begin
                illegal_d = 1'b1;
            end else if (wdec[6]) begin
                inh_d = wval & INH_MASK;
            end else begin
                for (int unsigned k = 0; k < NUM_CNT; k++) begin
                    if (wdec[4:0] == 5'(k)) cnt_d[k] = wnew[CNT_WIDTH-1:0];
                end
            end
        end
    end

    // State and response registers; reset overrides all activity
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= '0;
            end
            inh_q     <= 32'd0;
            rdata_q   <= 32'd0;
            rvalid_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            inh_q     <= inh_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Randomized scoreboard bench for csr_counter_unit against an address-map
// based reference model of the counters.
module tb_csr_counter_unit;
    localparam int unsigned NUM_HPM   = 4;
    localparam int unsigned CNT_WIDTH = 40;
    localparam int unsigned NC        = NUM_HPM + 2;

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inst_done = 1'b0;
    logic [NUM_HPM-1:0] hpm_event = '0;

    csr_counter_unit_if bus ();

    csr_counter_unit #(.NUM_HPM(NUM_HPM), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .csr       (bus),
        .inst_done (inst_done),
        .hpm_event (hpm_event)
    );

    always #5 clk = ~clk;

    exp_t            q[$];
    longint unsigned m_cnt[NC];
    longint unsigned cmask;
    int unsigned     m_inh;
    int unsigned     inh_mask;
    int              rmap[int];
    int              wmap[int];
    int              r_addrs[$];
    int              w_addrs[$];
    int              checks = 0;
    int              errors = 0;
    bit              mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Address map: code = (slot << 1) | high_half, -1 = mcountinhibit
    task automatic build_maps();
        for (int i = 0; i < int'(NC); i++) begin
            rmap['hC00 + ((i == 0) ? 0 : i + 1)] = i << 1;
            rmap['hC80 + ((i == 0) ? 0 : i + 1)] = (i << 1) | 1;
            wmap['hB00 + ((i == 0) ? 0 : i + 1)] = i << 1;
            wmap['hB80 + ((i == 0) ? 0 : i + 1)] = (i << 1) | 1;
        end
        rmap['hC01] = 0;
        rmap['hC81] = 1;
        foreach (wmap[a]) rmap[a] = wmap[a];
        rmap['h320] = -1;
        wmap['h320] = -1;
        foreach (rmap[a]) r_addrs.push_back(a);
        foreach (wmap[a]) w_addrs.push_back(a);
    endtask

    function automatic logic [31:0] view(input int code);
        longint unsigned v;
        if (code < 0) return m_inh;
        v = m_cnt[code >> 1];
        return (code & 1) ? v[63:32] : v[31:0];
    endfunction

    // One clock of stimulus; the model predicts the response that follows this edge
    task automatic step(input bit r, input logic [11:0] ra, input bit w, input logic [11:0] wa,
                        input logic [31:0] wd, input logic [1:0] op, input bit id,
                        input logic [NUM_HPM-1:0] ev, input bit rs);
        exp_t            e;
        bit              wil;
        bit              inc;
        int              code;
        logic [31:0]     old, nv;
        longint unsigned full;
        longint unsigned nxt[NC];
        int unsigned     nxt_inh;

        bus.csr_ren   = r;
        bus.csr_raddr = ra;
        bus.csr_wen   = w;
        bus.csr_waddr = wa;
        bus.csr_wdata = wd;
        bus.csr_op    = op;
        inst_done     = id;
        hpm_event     = ev;
        rst           = rs;

        if (rs) begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_inh = 0;
        end else begin
            e.rv = r; e.rd = 32'd0; e.ill = 1'b0;
            if (r) begin
                if (rmap.exists(int'(ra))) e.rd = view(rmap[int'(ra)]);
                else e.ill = 1'b1;
            end
            wil = w && !wmap.exists(int'(wa));
            if (wil) e.ill = 1'b1;
            if (r || wil) q.push_back(e);

            for (int k = 0; k < int'(NC); k++) begin
                if (k == 0)      inc = (m_inh & 1) == 0;
                else if (k == 1) inc = id && ((m_inh >> 2) & 1) == 0;
                else             inc = ev[k-2] && ((m_inh >> (k + 1)) & 1) == 0;
                nxt[k] = (m_cnt[k] + (inc ? 64'd1 : 64'd0)) & cmask;
            end
            nxt_inh = m_inh;
            if (w && !wil) begin
                code = wmap[int'(wa)];
                old  = view(code);
                nv   = (op == 2'b01) ? (old | wd) : (op == 2'b10) ? (old & ~wd) : wd;
                if (code < 0) begin
                    nxt_inh = nv & inh_mask;
                end else begin
                    full = m_cnt[code >> 1];
                    if (code & 1) full = {nv, full[31:0]};
                    else          full = {full[63:32], nv};
                    nxt[code >> 1] = full & cmask;
                end
            end
            foreach (m_cnt[k]) m_cnt[k] = nxt[k];
            m_inh = nxt_inh;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 12'h0, 0, 12'h0, 32'h0, 2'b00, 0, '0, 0);
    endtask

    task automatic rd(input logic [11:0] a);
        step(1, a, 0, 12'h0, 32'h0, 2'b00, 0, '0, 0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] op);
        step(0, 12'h0, 1, a, d, op, 0, '0, 0);
    endtask

    function automatic logic [11:0] pick(input bit for_write);
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 7) begin
            if (for_write) return 12'(w_addrs[$urandom_range(0, w_addrs.size() - 1)]);
            return 12'(r_addrs[$urandom_range(0, r_addrs.size() - 1)]);
        end
        if (sel == 7) return 12'(r_addrs[$urandom_range(0, r_addrs.size() - 1)]);
        if (sel == 8) return 12'(12'hB00 | 12'($urandom_range(0, 255)));
        return 12'($urandom_range(0, 4095));
    endfunction

    // Monitor: every response pulse must match the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.csr_rvalid === 1'b1 || bus.csr_illegal === 1'b1) begin
                    if (q.size() == 0) begin
                        chk("unexpected_response", {30'd0, bus.csr_rvalid, bus.csr_illegal}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rvalid", {31'd0, bus.csr_rvalid}, {31'd0, e.rv});
                        chk("rdata", bus.csr_rdata, e.rd);
                        chk("illegal", {31'd0, bus.csr_illegal}, {31'd0, e.ill});
                    end
                end else if (bus.csr_rdata !== 32'd0) begin
                    chk("rdata_idle_zero", bus.csr_rdata, 32'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cmask    = (64'd1 << CNT_WIDTH) - 64'd1;
        inh_mask = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_inh = 0;
        build_maps();

        // Reset with concurrent activity
        for (int i = 0; i < 3; i++) step(1, 12'hC00, 1, 12'hB00, 32'h1234, 2'b00, 1, '1, 1);
        chk("reset_rvalid", {31'd0, bus.csr_rvalid}, 32'd0);
        chk("reset_rdata", bus.csr_rdata, 32'd0);
        chk("reset_illegal", {31'd0, bus.csr_illegal}, 32'd0);
        mon_en = 1'b1;

        // Cycle count after release
        idle(3);
        rd(12'hC00);
        idle(1);

        // Carry into the high half of mcycle
        wr(12'hB00, 32'hFFFF_FFFF, 2'b00);
        wr(12'hB80, 32'h0, 2'b00);
        idle(1);
        rd(12'hC80);

        // Bits above CNT_WIDTH and minstret wrap
        wr(12'hB82, 32'hFFFF_FFFF, 2'b00);
        rd(12'hC82);
        wr(12'hB02, 32'hFFFF_FFFF, 2'b00);
        step(1, 12'hC02, 0, 12'h0, 32'h0, 2'b00, 1, '0, 0);
        rd(12'hC02);
        rd(12'hC82);

        // Inhibit set/clear; write cycle still uses the old inhibit
        wr(12'h320, 32'h5, 2'b01);
        for (int i = 0; i < 4; i++) step(1, 12'hC00 + 12'(i), 0, 12'h0, 32'h0, 2'b00, 1, 4'b0001, 0);
        rd(12'h320);
        wr(12'h320, 32'h1, 2'b10);
        idle(2);
        rd(12'hC00);
        rd(12'hC02);
        rd(12'hC03);

        // Illegal accesses
        wr(12'hC00, 32'hDEAD_BEEF, 2'b00);
        rd(12'hB03 + 12'(NUM_HPM));
        rd(12'hB01);
        rd(12'hC00);

        // Write beats a same-cycle event; read-during-write returns the old value
        step(1, 12'hB03, 1, 12'hB03, 32'h10, 2'b00, 0, 4'b0001, 0);
        rd(12'hC03);
        step(1, 12'hB00, 1, 12'hB00, 32'hF0, 2'b10, 1, '1, 0);
        rd(12'hB00);

        // Randomized traffic with occasional mid-stream reset
        for (int n = 0; n < 1500; n++) begin
            step(1'($urandom_range(0, 1)), pick(0), ($urandom_range(0, 3) == 0), pick(1),
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom(),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 NUM_HPM'($urandom()), ($urandom_range(0, 299) == 0));
        end

        // Reset mid-stream, then read every view
        step(1, 12'hC00, 1, 12'hB02, 32'h55, 2'b00, 1, '1, 1);
        foreach (r_addrs[i]) rd(12'(r_addrs[i]));

        idle(3);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
